zero_extend_unit: RTL and testbench

Widens an unsigned immediate field, default 8 bits, to the datapath word, default 16 bits, by filling the upper bits with zeros. It sits between the instruction decoder and the ALU/stack-push mux of the stack processor. The block provides two outputs:
- a combinational result for same-cycle use;
- a registered copy with a valid flag for pipelined use.

---
 rtl/zero_extend_unit.sv | 54 +++++
 tb/tb_zero_extend_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/zero_extend_unit.sv
// Zero-extends an unsigned immediate to the datapath word width.
// Provides a combinational result and a registered copy qualified by out_valid.
module zero_extend_unit #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] extended,
  output logic [OUT_WIDTH-1:0] extended_q,
  output logic                 out_valid
);

  generate
    if (OUT_WIDTH < IN_WIDTH) begin : g_width_check
      $error("zero_extend_unit: OUT_WIDTH (%0d) must be >= IN_WIDTH (%0d)", OUT_WIDTH, IN_WIDTH);
    end
  endgenerate

  logic [OUT_WIDTH-1:0] extended_next;
  logic [OUT_WIDTH-1:0] extended_q_reg;
  logic                 out_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < IN_WIDTH; gi++) begin : g_data
      assign extended_next[gi] = in[gi];
    end
    // Padding is tied to constant zero so the MSB of in never leaks upward.
    for (gi = IN_WIDTH; gi < OUT_WIDTH; gi++) begin : g_pad
      assign extended_next[gi] = 1'b0;
    end
  endgenerate

  assign extended = extended_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      extended_q_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      if (in_valid) begin
        extended_q_reg <= extended_next;
      end
      out_valid_reg <= in_valid;
    end
  end

  assign extended_q = extended_q_reg;
  assign out_valid  = out_valid_reg;

endmodule

// File: tb/tb_zero_extend_unit.sv
// Directed, table-driven bench for zero_extend_unit (8 -> 16 bits).
module tb_zero_extend_unit;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [7:0]  in;
  logic        in_valid;
  logic [15:0] extended;
  logic [15:0] extended_q;
  logic        out_valid;

  int checks;
  int failures;

  zero_extend_unit #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .extended   (extended),
    .extended_q (extended_q),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic [7:0]  din;
    logic [15:0] exp;
  } comb_vec_t;

  typedef struct {
    logic [7:0]  din;
    logic [15:0] exp_q;
  } stream_vec_t;

  comb_vec_t   comb_tab[7];
  stream_vec_t stream_tab[3];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in       = 8'd0;

    comb_tab[0] = '{8'd0,   16'h0000};
    comb_tab[1] = '{8'd97,  16'h0061};
    comb_tab[2] = '{8'd128, 16'h0080};
    comb_tab[3] = '{8'd223, 16'h00DF};
    comb_tab[4] = '{8'd255, 16'h00FF};
    comb_tab[5] = '{8'd127, 16'h007F};
    comb_tab[6] = '{8'd1,   16'h0001};

    stream_tab[0] = '{8'd0,   16'h0000};
    stream_tab[1] = '{8'd128, 16'h0080};
    stream_tab[2] = '{8'd223, 16'h00DF};

    // Combinational path with the clock stopped.
    for (int i = 0; i < 7; i++) begin
      in = comb_tab[i].din;
      #100;
      check16($sformatf("comb in=%0d", comb_tab[i].din), extended, comb_tab[i].exp);
    end

    // Reset held for two edges with a capture request present.
    reset    = 1'b1;
    in       = 8'd200;
    in_valid = 1'b1;
    clk_en   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      check16($sformatf("reset edge%0d extended_q", i), extended_q, 16'h0000);
      check1($sformatf("reset edge%0d out_valid", i), out_valid, 1'b0);
      check16($sformatf("reset edge%0d extended", i), extended, 16'd200);
    end

    // Single capture, then hold.
    @(negedge clk);
    reset    = 1'b0;
    in       = 8'd97;
    in_valid = 1'b1;
    edge_sample();
    check16("capture edge1 extended_q", extended_q, 16'd97);
    check1("capture edge1 out_valid", out_valid, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    edge_sample();
    check16("capture edge2 extended_q", extended_q, 16'd97);
    check1("capture edge2 out_valid", out_valid, 1'b0);
    @(negedge clk);
    in = 8'd5;
    edge_sample();
    check16("hold extended_q", extended_q, 16'd97);
    check1("hold out_valid", out_valid, 1'b0);
    check16("hold extended", extended, 16'd5);

    // Back-to-back captures.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in       = stream_tab[i].din;
      in_valid = 1'b1;
      edge_sample();
      check16($sformatf("stream%0d extended_q", i), extended_q, stream_tab[i].exp_q);
      check1($sformatf("stream%0d out_valid", i), out_valid, 1'b1);
    end

    // Reset collides with a capture request.
    @(negedge clk);
    in       = 8'd50;
    in_valid = 1'b1;
    reset    = 1'b1;
    edge_sample();
    check16("collision extended_q", extended_q, 16'h0000);
    check1("collision out_valid", out_valid, 1'b0);
    check16("collision extended", extended, 16'd50);

    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    clk_en   = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
